fifo_cmd_driver: RTL and testbench
==================================

# fifo_cmd_driver

Command-side driver for the opcode-vector FIFO. It converts a producer valid/ready write stream and a consumer read-request stream into one `{opcode, data}` vector per clock and tracks FIFO occupancy with a credit counter. It returns read data with a fixed-latency valid strobe and sequences the FIFO's own synchronous reset. It sits directly in front of the FIFO: its `vector_out` drives the FIFO's `vector_in`, and the FIFO's `data_out` feeds back into `fifo_data_in`.

## Interface
- DATA_WIDTH, 4, payload width; must match the FIFO.
- NUM_ENTRIES, 4, FIFO depth; power of two, 2..256.
- OPCODE_WIDTH, 2, opcode field width.
- CNT_WIDTH, LOG2(NUM_ENTRIES)+1, occupancy counter width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- wr_valid  in  1  producer has a word.
- wr_data  in  DATA_WIDTH  producer word.
- wr_ready  out  1  write accepted this cycle when high with wr_valid.
- rd_req  in  1  consumer requests one word.
- rd_ready  out  1  read accepted this cycle when high with rd_req.
- rd_data  out  DATA_WIDTH  returned word.
- rd_data_valid  out  1  one-cycle strobe qualifying rd_data.
- flush  in  1  pulse; discard all FIFO contents.
- flush_busy  out  1  high while in INIT or FLUSH.
- occupancy  out  CNT_WIDTH  credit count, 0..NUM_ENTRIES.
- vector_out  out  OPCODE_WIDTH+DATA_WIDTH  `{opcode, data}` to the FIFO.
- fifo_rst  out  1  active-high synchronous reset to the FIFO.
- fifo_data_in  in  DATA_WIDTH  FIFO data_out.

## Operation
- States:
  - INIT: fifo_rst=1, no commands.
  - RUN: normal traffic.
  - FLUSH: drain.
- Transitions:
  - Reset → INIT.
  - INIT → RUN after 2 edges.
  - RUN → FLUSH on `flush` (ignored outside RUN).
  - FLUSH → RUN when occupancy==0 and no read is in flight.
- Write eligible: RUN, occupancy<NUM_ENTRIES, wr_valid.
- Read eligible: RUN, occupancy>0, rd_req.
- Only one operation per cycle. If both are eligible, grant the opposite of the last grant. The last-grant register resets to READ, so the first contention goes to WRITE.
- wr_ready / rd_ready are combinational from registered state, occupancy, the other request, and the last-grant register.
- Write grant: vector_out ← {WRITE=2'b10, wr_data}; occupancy+1.
- Read grant: vector_out ← {READ=2'b01, 0}; occupancy−1.
- No grant: vector_out ← {DO_NOTHING=2'b00, 0}.
- Never emit INVALID=2'b11. Never write at NUM_ENTRIES or read at 0.
- FLUSH:
  - wr_ready and rd_ready are held 0.
  - Issue READ every cycle while occupancy>0.
  - Returned data is discarded and rd_data_valid is suppressed.
- Occupancy uses plain ±1 arithmetic and never wraps; reaching out of range is an assertion failure.

## Timing
- Reset values:
  - vector_out = 0; fifo_rst = 1 (asserted asynchronously).
  - rd_data = 0; rd_data_valid = 0; occupancy = 0.
  - wr_ready = rd_ready = 0; flush_busy = 1.
  - state = INIT.
- All outputs are registered except wr_ready and rd_ready.
- Read latency, for a read granted at edge E:
  - vector_out = READ from E.
  - The FIFO executes at E+1.
  - rd_data captures fifo_data_in at E+2, and rd_data_valid is high for the cycle after E+2.
- Reads are fully pipelined, so back-to-back grants give back-to-back strobes.
- In-flight tracking uses a 2-bit shift register tagging each read as deliver or discard.
- Reset mid-operation: all state clears immediately, in-flight reads are lost without a strobe, and INIT reruns.
- A flush arriving in the same cycle as a RUN grant: the grant completes first, then FLUSH begins on the next edge.

## Configuration
- `FIFO_CMD_DRIVER_STATS_EN` defined: adds output ports `wr_count` and `rd_count` (16-bit).
  - Each counts granted operations, saturating at 16'hFFFF.
  - Both clear on reset.
  - FLUSH reads count in rd_count.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package (`fifo_pkg`):
  - opcode constants READ, WRITE, DO_NOTHING, INVALID.
  - DATA_VALID / FIFO_FULL / FIFO_EMPTY flag constants.
  - the LOG2 macro.
  - driver state encoding (INIT=2'd0, RUN=2'd1, FLUSH=2'd2).
- One sub-module, `fifo_rd_return`: the 2-stage in-flight tag pipeline plus the rd_data / rd_data_valid capture register.

## Test plan
- Reset release → fifo_rst=1 for 2 edges, then 0; flush_busy falls; vector_out stays 6'b00_0000 throughout.
- Write 4'h3, 4'h7, 4'h9, 4'hC → vector_out 10_0011, 10_0111, 10_1001, 10_1100; occupancy 4; wr_ready=0 while a fifth word is held.
- Four reads after the fills → rd_data_valid strobes 2 cycles after each grant, with data 3, 7, 9, C in order; occupancy returns to 0; rd_ready=0 on a fifth request.
- wr_valid and rd_req held high with occupancy 2 → grants alternate WRITE, READ, WRITE, …; occupancy oscillates 3, 2, 3.
- Occupancy 3, then flush pulse → three READ vectors, no rd_data_valid, occupancy 0; return to RUN 2 cycles after the last READ.
- Reset asserted 1 cycle after a read grant → no strobe; all outputs at reset values immediately; INIT reruns on release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the opcode-vector FIFO and its command driver:
// opcode and driver-state encodings, status flag bit positions and the LOG2 macro.
`ifndef LOG2
`define LOG2(x) ($clog2(x))
`endif

package fifo_pkg;

   typedef enum logic [1:0] {
      DO_NOTHING = 2'b00,
      READ       = 2'b01,
      WRITE      = 2'b10,
      INVALID    = 2'b11
   } opcode_t;

   // Bit positions within the FIFO status flag vector
   localparam int DATA_VALID = 0;
   localparam int FIFO_FULL  = 1;
   localparam int FIFO_EMPTY = 2;
   localparam int NUM_FLAGS  = 3;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } drv_state_t;

   typedef struct packed {
      logic vld;
      logic deliver;
   } rd_tag_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fifo_cmd_driver_if.sv
// Producer write stream and consumer read stream of the FIFO command driver.
// master = traffic source/sink side, slave = driver side.
interface fifo_cmd_driver_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  rd_req;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;

   modport master (
      output wr_valid, wr_data, rd_req,
      input  wr_ready, rd_ready, rd_data, rd_data_valid
   );

   modport slave (
      input  wr_valid, wr_data, rd_req,
      output wr_ready, rd_ready, rd_data, rd_data_valid
   );
endinterface

// File: rtl/fifo_rd_return.sv
// Read return path: two-stage in-flight tag pipeline plus rd_data capture.
// Data captured two edges after issue, strobe the following cycle; no backpressure.
module fifo_rd_return
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue,
   input  logic                  deliver,
   input  logic [DATA_WIDTH-1:0] fifo_data_in,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  pending
);

   rd_tag_t stage0;
   rd_tag_t stage1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage0        <= '0;
         stage1        <= '0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
      end else begin
         stage0        <= rd_tag_t'{vld: issue, deliver: issue & deliver};
         stage1        <= stage0;
         rd_data_valid <= stage1.vld & stage1.deliver;
         // Discarded (flush) reads leave the last delivered word in place
         if (stage1.vld && stage1.deliver) begin
            rd_data <= fifo_data_in;
         end
      end
   end

   // stage1 retires at the coming edge, so only stage0 is still outstanding afterwards
   assign pending = stage0.vld;

endmodule

// File: rtl/fifo_cmd_driver.sv
// Merges write/read streams into one {opcode,data} FIFO command per clock with credit tracking.
// Read data returns 2 edges after grant; ready drops at full/empty or outside RUN. Optional FIFO_CMD_DRIVER_STATS_EN adds grant counters.
module fifo_cmd_driver
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 4,
   parameter int NUM_ENTRIES  = 4,
   parameter int OPCODE_WIDTH = 2,
   parameter int CNT_WIDTH    = `LOG2(NUM_ENTRIES) + 1
) (
   input  logic                             clk,
   input  logic                             reset,
   fifo_cmd_driver_if.slave                 bus,
   input  logic                             flush,
   output logic                             flush_busy,
   output logic [CNT_WIDTH-1:0]             occupancy,
   output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out,
   output logic                             fifo_rst,
   input  logic [DATA_WIDTH-1:0]            fifo_data_in
`ifdef FIFO_CMD_DRIVER_STATS_EN
   ,
   output logic [15:0]                      wr_count,
   output logic [15:0]                      rd_count
`endif
);

   drv_state_t state;
   drv_state_t state_d;
   logic       init_cnt;
   logic       last_write;
   logic       full;
   logic       empty;
   logic       wr_elig;
   logic       rd_elig;
   logic       flush_rd;
   logic       wr_grant;
   logic       rd_grant;
   logic       rd_issue;
   logic       pending;

   assign full  = (occupancy == CNT_WIDTH'(NUM_ENTRIES));
   assign empty = (occupancy == '0);

   always_comb begin
      state_d      = state;
      bus.wr_ready = 1'b0;
      bus.rd_ready = 1'b0;
      flush_rd     = 1'b0;
      wr_elig      = (state == RUN) && !full && bus.wr_valid;
      rd_elig      = (state == RUN) && !empty && bus.rd_req;
      case (state)
         INIT: begin
            if (init_cnt) state_d = RUN;
         end
         RUN: begin
            // On contention the side that did not win last time gets the slot
            bus.wr_ready = !full && (!rd_elig || !last_write);
            bus.rd_ready = !empty && (!wr_elig || last_write);
            if (flush) state_d = FLUSH;
         end
         FLUSH: begin
            flush_rd = !empty;
            if (empty && !pending) state_d = RUN;
         end
         default: state_d = INIT;
      endcase
   end

   assign wr_grant = bus.wr_valid & bus.wr_ready;
   assign rd_grant = bus.rd_req & bus.rd_ready;
   assign rd_issue = rd_grant | flush_rd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= INIT;
         init_cnt   <= 1'b0;
         last_write <= 1'b0;
         occupancy  <= '0;
         vector_out <= '0;
         fifo_rst   <= 1'b1;
         flush_busy <= 1'b1;
      end else begin
         state      <= state_d;
         init_cnt   <= (state == INIT);
         fifo_rst   <= (state_d == INIT);
         flush_busy <= (state_d != RUN);
         if (wr_grant) begin
            occupancy  <= occupancy + CNT_WIDTH'(1);
            last_write <= 1'b1;
            vector_out <= {OPCODE_WIDTH'(WRITE), bus.wr_data};
         end else if (rd_issue) begin
            occupancy  <= occupancy - CNT_WIDTH'(1);
            if (rd_grant) last_write <= 1'b0;
            vector_out <= {OPCODE_WIDTH'(READ), {DATA_WIDTH{1'b0}}};
         end else begin
            vector_out <= {OPCODE_WIDTH'(DO_NOTHING), {DATA_WIDTH{1'b0}}};
         end
      end
   end

   fifo_rd_return #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_return (
      .clk           (clk),
      .reset         (reset),
      .issue         (rd_issue),
      .deliver       (rd_grant),
      .fifo_data_in  (fifo_data_in),
      .rd_data       (bus.rd_data),
      .rd_data_valid (bus.rd_data_valid),
      .pending       (pending)
   );

`ifdef FIFO_CMD_DRIVER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (wr_grant) wr_count <= sat_inc(wr_count);
         if (rd_issue) rd_count <= sat_inc(rd_count);
      end
   end
`endif

   a_occ_range: assert property (@(posedge clk) disable iff (!reset)
      occupancy <= CNT_WIDTH'(NUM_ENTRIES));
   a_no_invalid: assert property (@(posedge clk) disable iff (!reset)
      vector_out[OPCODE_WIDTH+DATA_WIDTH-1 -: OPCODE_WIDTH] != OPCODE_WIDTH'(INVALID));
   a_one_op: assert property (@(posedge clk) disable iff (!reset)
      !(wr_grant && rd_issue));

endmodule

// File: tb/tb_fifo_cmd_driver.sv
// Directed bench for fifo_cmd_driver with a small behavioural FIFO closing the loop.
module tb_fifo_cmd_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       flush_busy;
   logic [2:0] occupancy;
   logic [5:0] vector_out;
   logic       fifo_rst;
   logic [3:0] fifo_data_in;
`ifdef FIFO_CMD_DRIVER_STATS_EN
   logic [15:0] wr_count;
   logic [15:0] rd_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] pat [4];

   fifo_cmd_driver_if #(.DATA_WIDTH(4)) bus ();

   fifo_cmd_driver #(
      .DATA_WIDTH(4), .NUM_ENTRIES(4), .OPCODE_WIDTH(2), .CNT_WIDTH(3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .flush        (flush),
      .flush_busy   (flush_busy),
      .occupancy    (occupancy),
      .vector_out   (vector_out),
      .fifo_rst     (fifo_rst),
      .fifo_data_in (fifo_data_in)
`ifdef FIFO_CMD_DRIVER_STATS_EN
      ,
      .wr_count     (wr_count),
      .rd_count     (rd_count)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: executes the command registered in vector_out
   logic [3:0] fmem [4];
   logic [1:0] fwp;
   logic [1:0] frp;
   always @(posedge clk) begin
      if (fifo_rst) begin
         fwp <= 2'd0;
         frp <= 2'd0;
         fifo_data_in <= 4'h0;
      end else begin
         case (vector_out[5:4])
            2'b10: begin fmem[fwp] <= vector_out[3:0]; fwp <= fwp + 2'd1; end
            2'b01: begin fifo_data_in <= fmem[frp]; frp <= frp + 2'd1; end
            default: ;
         endcase
      end
   end

   task automatic test_reset();
      bus.wr_valid = 1'b0; bus.wr_data = 4'h0; bus.rd_req = 1'b0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (vector_out !== 6'h00) begin n_fail++; $display("FAIL rst_vector got %b want 000000", vector_out); end
      n_checks++; if (fifo_rst !== 1'b1) begin n_fail++; $display("FAIL rst_fifo_rst got %b want 1", fifo_rst); end
      n_checks++; if (bus.rd_data !== 4'h0 || bus.rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd got %h/%b want 0/0", bus.rd_data, bus.rd_data_valid); end
      n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ got %0d want 0", occupancy); end
      n_checks++; if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b%b want 00", bus.wr_ready, bus.rd_ready); end
      n_checks++; if (flush_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b want 1", flush_busy); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (fifo_rst !== 1'b1 || flush_busy !== 1'b1 || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL init_edge1 got rst=%b busy=%b wr_ready=%b want 1 1 0", fifo_rst, flush_busy, bus.wr_ready); end
      n_checks++; if (vector_out !== 6'h00) begin n_fail++; $display("FAIL init_vector got %b want 000000", vector_out); end
      @(negedge clk);
      n_checks++; if (fifo_rst !== 1'b0 || flush_busy !== 1'b0) begin n_fail++; $display("FAIL init_edge2 got rst=%b busy=%b want 0 0", fifo_rst, flush_busy); end
      n_checks++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0 || vector_out !== 6'h00) begin n_fail++; $display("FAIL run_idle got wr_ready=%b rd_ready=%b vec=%b want 1 0 000000", bus.wr_ready, bus.rd_ready, vector_out); end
   endtask

   task automatic test_write();
      for (int i = 0; i < 4; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = pat[i];
         @(negedge clk);
         n_checks++; if (vector_out !== {2'b10, pat[i]}) begin n_fail++; $display("FAIL wr_vector[%0d] got %b want %b", i, vector_out, {2'b10, pat[i]}); end
         n_checks++; if (occupancy !== 3'(i + 1)) begin n_fail++; $display("FAIL wr_occ[%0d] got %0d want %0d", i, occupancy, i + 1); end
      end
      bus.wr_data = 4'h5;
      #1;
      n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_full_ready got %b want 0", bus.wr_ready); end
      @(negedge clk);
      n_checks++; if (vector_out !== 6'h00 || occupancy !== 3'd4) begin n_fail++; $display("FAIL wr_full_hold got vec=%b occ=%0d want 000000 4", vector_out, occupancy); end
      bus.wr_valid = 1'b0;
   endtask

   task automatic test_read();
      bus.rd_req = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         n_checks++;
         if (vector_out !== ((k <= 4) ? 6'b01_0000 : 6'b00_0000) || occupancy !== ((k <= 4) ? 3'(4 - k) : 3'd0)) begin
            n_fail++; $display("FAIL rd_cmd[%0d] got vec=%b occ=%0d", k, vector_out, occupancy);
         end
         n_checks++; if (bus.rd_data_valid !== (k >= 3 && k <= 6)) begin n_fail++; $display("FAIL rd_valid[%0d] got %b want %b", k, bus.rd_data_valid, (k >= 3 && k <= 6)); end
         if (k >= 3 && k <= 6) begin
            n_checks++; if (bus.rd_data !== pat[k-3]) begin n_fail++; $display("FAIL rd_data[%0d] got %h want %h", k, bus.rd_data, pat[k-3]); end
         end
         if (k == 4) begin
            n_checks++; if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_empty_ready got %b want 0", bus.rd_ready); end
            bus.rd_req = 1'b0;
         end
      end
   endtask

   task automatic test_alternate();
      logic [3:0] pre [3];
      pre[0] = 4'h1; pre[1] = 4'h2; pre[2] = 4'h4;
      for (int i = 0; i < 3; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = pre[i];
         @(negedge clk);
      end
      bus.wr_valid = 1'b0; bus.rd_req = 1'b1;
      @(negedge clk);
      n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL alt_setup_occ got %0d want 2", occupancy); end
      bus.wr_valid = 1'b1; bus.wr_data = 4'hE; bus.rd_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (vector_out !== ((k % 2 == 0) ? 6'b10_1110 : 6'b01_0000) || occupancy !== ((k % 2 == 0) ? 3'd3 : 3'd2)) begin
            n_fail++; $display("FAIL alt[%0d] got vec=%b occ=%0d", k, vector_out, occupancy);
         end
         if (k == 0) begin
            n_checks++; if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b1) begin n_fail++; $display("FAIL alt_ready got %b%b want 01", bus.wr_ready, bus.rd_ready); end
         end
      end
      bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
   endtask

   task automatic test_flush();
      repeat (3) @(negedge clk);
      n_checks++; if (occupancy !== 3'd3 || bus.rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL fl_pre got occ=%0d valid=%b want 3 0", occupancy, bus.rd_data_valid); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++; if (flush_busy !== 1'b1 || vector_out !== 6'h00) begin n_fail++; $display("FAIL fl_start got busy=%b vec=%b want 1 000000", flush_busy, vector_out); end
      bus.wr_valid = 1'b1; bus.rd_req = 1'b1;
      #1;
      n_checks++; if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b%b want 00", bus.wr_ready, bus.rd_ready); end
      bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (vector_out !== ((k <= 3) ? 6'b01_0000 : 6'b00_0000) || occupancy !== ((k <= 3) ? 3'(3 - k) : 3'd0)) begin
            n_fail++; $display("FAIL fl_cmd[%0d] got vec=%b occ=%0d", k, vector_out, occupancy);
         end
         n_checks++; if (flush_busy !== (k <= 4) || bus.rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL fl_state[%0d] got busy=%b valid=%b want %b 0", k, flush_busy, bus.rd_data_valid, (k <= 4)); end
      end
   endtask

   task automatic test_reset_mid();
      bus.wr_valid = 1'b1; bus.wr_data = 4'h6;
      @(negedge clk);
      bus.wr_valid = 1'b0; bus.rd_req = 1'b1;
      @(negedge clk);
      bus.rd_req = 1'b0;
      n_checks++; if (vector_out !== 6'b01_0000) begin n_fail++; $display("FAIL mid_read got %b want 010000", vector_out); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (vector_out !== 6'h00 || fifo_rst !== 1'b1 || occupancy !== 3'd0 || bus.rd_data !== 4'h0 ||
          bus.rd_data_valid !== 1'b0 || flush_busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_outputs got vec=%b rst=%b occ=%0d data=%h valid=%b busy=%b rdy=%b%b", vector_out, fifo_rst, occupancy, bus.rd_data, bus.rd_data_valid, flush_busy, bus.wr_ready, bus.rd_ready);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++; if (bus.rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_strobe[%0d] got %b want 0", k, bus.rd_data_valid); end
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (fifo_rst !== 1'b1 || flush_busy !== 1'b1 || bus.rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_init1 got rst=%b busy=%b valid=%b want 1 1 0", fifo_rst, flush_busy, bus.rd_data_valid); end
      @(negedge clk);
      n_checks++; if (fifo_rst !== 1'b0 || flush_busy !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_init2 got rst=%b busy=%b occ=%0d want 0 0 0", fifo_rst, flush_busy, occupancy); end
   endtask

   initial begin
      pat[0] = 4'h3; pat[1] = 4'h7; pat[2] = 4'h9; pat[3] = 4'hC;
      test_reset();
      test_write();
      test_read();
      test_alternate();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
